// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline sequencer: RAW interlock over EX/MEM/WB, multi-cycle EX hold, branch flush.
// Latency: all controls are combinational from the current state and the decode inputs.
// Backpressure: stalls the front end on a hazard or busy EX; a flush overrides both.
module pipe_hazard_ctrl #(
   parameter int RA_W   = 3,
   parameter int MC_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic             id_rs1_en,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic             id_rs2_en,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             id_rd_en,
   input  logic             id_vec,
   input  logic             id_mc,
   input  logic             ex_branch_taken,
   output logic             en_if,
   output logic             en_id,
   output logic             flush_id,
   output logic             en_ex,
   output logic             ex_bubble,
   output logic             mem_bubble,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int EXC_W = $clog2(MC_LAT);

   typedef struct packed {
      logic            v;
      logic [RA_W-1:0] rd;
      logic            vec;
   } slot_t;

   slot_t            ex_q, mem_q, wb_q;
   logic [EXC_W-1:0] ex_cnt;
   logic             busy, flush, hazard;

   function automatic logic hit(input slot_t s, input logic [RA_W-1:0] rs,
                                input logic en, input logic vec);
      return en && s.v && (s.vec == vec) && (s.rd == rs);
   endfunction

   assign busy  = (ex_cnt != '0);
   assign flush = ex_branch_taken && !busy;

   // The register file does not bypass, so a producer still in WB blocks its readers.
   always_comb begin
      hazard = 1'b0;
      if (id_valid) begin
         hazard = hit(ex_q,  id_rs1, id_rs1_en, id_vec) || hit(ex_q,  id_rs2, id_rs2_en, id_vec) ||
                  hit(mem_q, id_rs1, id_rs1_en, id_vec) || hit(mem_q, id_rs2, id_rs2_en, id_vec) ||
                  hit(wb_q,  id_rs1, id_rs1_en, id_vec) || hit(wb_q,  id_rs2, id_rs2_en, id_vec);
      end
   end

   always_comb begin
      en_if      = 1'b1;
      en_id      = 1'b1;
      flush_id   = 1'b0;
      en_ex      = 1'b1;
      ex_bubble  = 1'b0;
      mem_bubble = 1'b0;
      stall      = 1'b0;
      if (rst) begin
         en_if      = 1'b0;
         flush_id   = 1'b1;
         ex_bubble  = 1'b1;
         mem_bubble = 1'b1;
      end else if (flush) begin
         flush_id  = 1'b1;
         ex_bubble = 1'b1;
      end else if (busy) begin
         en_if      = 1'b0;
         en_id      = 1'b0;
         en_ex      = 1'b0;
         mem_bubble = 1'b1;
         stall      = 1'b1;
      end else if (hazard) begin
         en_if     = 1'b0;
         en_id     = 1'b0;
         ex_bubble = 1'b1;
         stall     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         ex_cnt    <= '0;
         stall_cnt <= '0;
      end else begin
         wb_q <= mem_q;
         if (flush) begin
            ex_q.v <= 1'b0;
            mem_q  <= ex_q;
         end else if (busy) begin
            // EX holds the multi-cycle op; MEM drains as a bubble.
            mem_q.v <= 1'b0;
            ex_cnt  <= ex_cnt - 1'b1;
         end else if (hazard) begin
            ex_q.v <= 1'b0;
            mem_q  <= ex_q;
            if (stall_cnt != '1)
               stall_cnt <= stall_cnt + 1'b1;
         end else begin
            ex_q   <= '{v: id_valid && id_rd_en, rd: id_rd, vec: id_vec};
            mem_q  <= ex_q;
            ex_cnt <= (id_valid && id_mc) ? EXC_W'(MC_LAT - 1) : '0;
         end
      end
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencer for the in-order scalar/vector core. Drives the enable and bubble controls of the fetch, decode and execute pipeline registers, including the enable of the execute-stage register. Tracks in-flight destination registers through EX/MEM/WB to stall read-after-write hazards, because there is no forwarding. Holds the pipeline for multi-cycle vector ops and flushes on a taken branch.

Parameters:
RA_W, 3, register address width (scalar and vector files each 2^RA_W entries)
MC_LAT, 4, execute occupancy in cycles of a multi-cycle vector op (>=2)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  decode stage holds a real instruction
id_rs1  in  RA_W  source 1 address
id_rs1_en  in  1  source 1 is read
id_rs2  in  RA_W  source 2 address
id_rs2_en  in  1  source 2 is read
id_rd  in  RA_W  destination address
id_rd_en  in  1  instruction writes back
id_vec  in  1  1 = sources/dest in vector file, 0 = scalar file
id_mc  in  1  instruction is multi-cycle in EX
ex_branch_taken  in  1  branch in EX resolved taken
en_if  out  1  fetch register / PC enable
en_id  out  1  decode register enable
flush_id  out  1  decode register loads NOP
en_ex  out  1  execute-stage register enable
ex_bubble  out  1  execute-stage register loads NOP (opcode 0, no writeback)
mem_bubble  out  1  memory-stage register loads NOP
stall  out  1  front end held this cycle (hazard or busy)
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- State: three scoreboard slots EX, MEM, WB, each {v, rd, vec}. ex_cnt is a down-counter of CNT width ceil(log2(MC_LAT)). stall_cnt.
- Reset (rst=1 at edge): all slot v=0, ex_cnt=0, stall_cnt=0.
- While rst=1, outputs are forced: en_if=0, en_id=1, flush_id=1, en_ex=1, ex_bubble=1, mem_bubble=1, stall=0.
- busy = (ex_cnt != 0).
- Match(s) = slot.v && slot.vec==id_vec && slot.rd==rs. Hazard applies to each enabled source.
- hazard = id_valid && (Match over EX, MEM or WB for rs1 or rs2). WB is included because the regfile does not bypass.
- flush = ex_branch_taken && !busy. ex_branch_taken is ignored while busy.
- Priority is flush > busy > hazard > advance. All outputs are combinational from state and inputs.
- flush: en_if=1, en_id=1, flush_id=1, en_ex=1, ex_bubble=1, mem_bubble=0, stall=0.
  - Next state: EX.v<=0, MEM<=EX, WB<=MEM.
- busy: en_if=0, en_id=0, flush_id=0, en_ex=0, ex_bubble=0, mem_bubble=1, stall=1.
  - Next state: EX held, MEM.v<=0, WB<=MEM, ex_cnt<=ex_cnt-1.
- hazard: en_if=0, en_id=0, en_ex=1, ex_bubble=1, mem_bubble=0, stall=1.
  - Next state: EX.v<=0, MEM<=EX, WB<=MEM, stall_cnt<=stall_cnt+1, saturating at all-ones.
- advance: en_if=en_id=en_ex=1, all bubbles 0, stall=0.
  - Next state: EX<={id_valid&&id_rd_en, id_rd, id_vec}, MEM<=EX, WB<=MEM.
  - ex_cnt<=MC_LAT-1 if id_valid&&id_mc, else 0.
- Multi-cycle op therefore occupies EX for exactly MC_LAT cycles: 1 entry cycle plus MC_LAT-1 busy cycles. Its result then moves to MEM on the cycle ex_cnt reaches 0.
- Hazard against a multi-cycle producer: the consumer waits until the producer leaves WB.
- Instruction with id_valid=0 never causes a hazard and enters EX as invalid.
- Source address 0 is not special; r0/v0 are tracked like any register.
- Reset mid-busy: ex_cnt and slots are cleared on that edge. The next cycle is a normal advance.

Test Plan:
- Reset: hold rst 2 cycles with id_valid=1 -> en_if=0, flush_id=1, ex_bubble=1 during reset; after release, slots empty, stall_cnt=0, stall=0.
- Back-to-back RAW, scalar: I0 rd=3, then I1 rs1=3 -> stall=1 for exactly 3 cycles (I0 in EX, MEM, WB); I1 enters EX on cycle 4; stall_cnt=3.
- Same address, different file: I0 vec rd=3, then I1 scalar rs1=3 -> no stall; independent stream advances 1 instr/cycle.
- Multi-cycle, MC_LAT=4: vec op with id_mc=1 then independent op -> stall=1, en_ex=0, mem_bubble=1 for 3 cycles. The follower enters EX on the 4th cycle after the mc op entered.
- Branch flush: ex_branch_taken=1 with I1 hazarding -> flush wins, flush_id=1, ex_bubble=1, stall=0, stall_cnt unchanged. ex_branch_taken=1 while busy -> ignored.
- Saturation: force 2^CNT_W+5 hazard cycles -> stall_cnt holds 16'hFFFF; rst asserted mid-busy -> ex_cnt=0, next cycle en_ex=1.
